// File: rtl/econet_pkg.sv
// Econet line constants shared by the transmitter and receiver, plus
// the bit-serial CRC-16/X.25 step used to build and check the FCS.
package econet_pkg;

    localparam logic [7:0]  ECO_FLAG = 8'h7E;
    localparam logic [15:0] FCS_POLY = 16'h8408;
    localparam logic [15:0] FCS_INIT = 16'hFFFF;
    localparam logic [15:0] FCS_GOOD = 16'hF0B8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLAG_OPEN,
        ST_DATA,
        ST_FCS,
        ST_FLAG_CLOSE
    } tx_state_e;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        crc_step = (crc >> 1) ^ (((crc[0] ^ b) == 1'b1) ? FCS_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/econet_tx_serialiser.sv
// HDLC-style frame serialiser: opening flags, bit-stuffed data and FCS,
// closing flag. Data bytes are fetched one ahead through a req/valid pair.
module econet_tx_serialiser
    import econet_pkg::*;
#(
    parameter int CNTW      = 9,
    parameter int PRE_FLAGS = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            go_i,
    input  logic [CNTW:0]   len_i,
    output logic            byte_req_o,
    output logic [CNTW-1:0] byte_idx_o,
    input  logic            byte_vld_i,
    input  logic [7:0]      byte_i,
    output logic            tx_o,
    output logic            tx_en_o,
    output logic            done_o
);

    localparam logic [3:0]    FLAG_LAST = 4'(PRE_FLAGS - 1);
    localparam logic [CNTW:0] ONE       = (CNTW+1)'(1);

    tx_state_e       state_q;
    logic [2:0]      bit_q;
    logic [3:0]      flag_q;
    logic [CNTW:0]   byte_q;
    logic [2:0]      ones_q;
    logic [15:0]     crc_q;
    logic [7:0]      shreg_q;
    logic [7:0]      pre_q;
    logic            fin_q;
    logic            tx_q;
    logic            en_q;
    logic            req_q;
    logic [CNTW-1:0] idx_q;

    logic        cur_bit;
    logic [2:0]  ones_nxt;
    logic [15:0] crc_nxt;
    logic        stuff;
    logic        last_byte;

    assign cur_bit   = shreg_q[bit_q];
    assign ones_nxt  = cur_bit ? ones_q + 3'd1 : 3'd0;
    assign crc_nxt   = crc_step(crc_q, cur_bit);
    assign stuff     = (ones_q == 3'd5);
    assign last_byte = (byte_q == len_i - ONE);

    assign tx_o       = tx_q;
    assign tx_en_o    = en_q;
    assign byte_req_o = req_q;
    assign byte_idx_o = idx_q;
    assign done_o     = (state_q == ST_FLAG_CLOSE) && fin_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            bit_q   <= 3'd0;
            flag_q  <= 4'd0;
            byte_q  <= '0;
            ones_q  <= 3'd0;
            crc_q   <= FCS_INIT;
            shreg_q <= 8'h00;
            pre_q   <= 8'h00;
            fin_q   <= 1'b0;
            tx_q    <= 1'b1;
            en_q    <= 1'b0;
            req_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            req_q <= 1'b0;
            if (byte_vld_i) pre_q <= byte_i;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    en_q <= 1'b0;
                    if (go_i) begin
                        state_q <= ST_FLAG_OPEN;
                        tx_q    <= ECO_FLAG[0];
                        en_q    <= 1'b1;
                        bit_q   <= 3'd1;
                        flag_q  <= 4'd0;
                        byte_q  <= '0;
                        ones_q  <= 3'd0;
                        crc_q   <= FCS_INIT;
                        fin_q   <= 1'b0;
                        req_q   <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                ST_FLAG_OPEN: begin
                    tx_q  <= ECO_FLAG[bit_q];
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (flag_q == FLAG_LAST) begin
                            state_q <= ST_DATA;
                            shreg_q <= pre_q;
                            ones_q  <= 3'd0;
                            req_q   <= 1'b1;
                            idx_q   <= CNTW'(1);
                        end else begin
                            flag_q <= flag_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (stuff) begin
                        tx_q   <= 1'b0;
                        ones_q <= 3'd0;
                    end else begin
                        tx_q   <= cur_bit;
                        crc_q  <= crc_nxt;
                        ones_q <= ones_nxt;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (last_byte) begin
                                state_q <= ST_FCS;
                                shreg_q <= ~crc_nxt[7:0];
                                byte_q  <= '0;
                            end else begin
                                // byte k+1 was prefetched a byte-time ago; ask for k+2
                                byte_q  <= byte_q + ONE;
                                shreg_q <= pre_q;
                                req_q   <= 1'b1;
                                idx_q   <= CNTW'(byte_q + ONE + ONE);
                            end
                        end
                    end
                end
                ST_FCS: begin
                    if (stuff) begin
                        tx_q   <= 1'b0;
                        ones_q <= 3'd0;
                    end else begin
                        tx_q   <= cur_bit;
                        ones_q <= ones_nxt;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (!byte_q[0]) begin
                                shreg_q <= ~crc_q[15:8];
                                byte_q  <= ONE;
                            end else begin
                                state_q <= ST_FLAG_CLOSE;
                            end
                        end
                    end
                end
                ST_FLAG_CLOSE: begin
                    if (fin_q) begin
                        tx_q    <= 1'b1;
                        en_q    <= 1'b0;
                        fin_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (stuff) begin
                        // ones run carried out of the FCS still needs its zero
                        tx_q   <= 1'b0;
                        ones_q <= 3'd0;
                    end else begin
                        tx_q  <= ECO_FLAG[bit_q];
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) fin_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/econet_tx_buffered.sv
// Buffered Econet transmitter: word-written frame buffer, start/length
// control and the sticky tx_done flag around the serialiser.
module econet_tx_buffered
    import econet_pkg::*;
#(
    parameter int ECO_BUFSZ    = 512,
    parameter int ECO_CNTWIDTH = 9,
    parameter int PRE_FLAGS    = 2
) (
    input  logic                    econet_clk,
    input  logic                    reset,
    input  logic                    sys_wr,
    input  logic                    sys_select,
    input  logic [7:0]              sys_addr,
    input  logic [31:0]             sys_wdata,
    input  logic [ECO_CNTWIDTH:0]   sys_tx_len,
    input  logic                    sys_tx_start,
    output logic                    econet_tx,
    output logic                    econet_tx_en,
    output logic                    tx_busy,
    output logic                    tx_done
);

    localparam int                    NWORDS = ECO_BUFSZ / 4;
    localparam int                    AW     = $clog2(NWORDS);
    localparam logic [ECO_CNTWIDTH:0] MAXLEN = (ECO_CNTWIDTH+1)'(ECO_BUFSZ);

    logic [31:0] mem_q [NWORDS];

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    go_q;
    logic [ECO_CNTWIDTH:0]   len_q;
    logic [7:0]              rbyte_q;
    logic                    rvld_q;

    logic                    wr_en;
    logic                    accept;
    logic                    ser_done;
    logic                    byte_req;
    logic [ECO_CNTWIDTH-1:0] byte_idx;
    logic [31:0]             rword;

    assign wr_en  = sys_wr && sys_select && !busy_q && (32'(sys_addr) < 32'(NWORDS));
    assign accept = sys_tx_start && !busy_q && (sys_tx_len != '0) && (sys_tx_len <= MAXLEN);
    assign rword  = mem_q[byte_idx[ECO_CNTWIDTH-1:2]];

    always_comb begin
        busy_d = busy_q;
        if (accept)        busy_d = 1'b1;
        else if (ser_done) busy_d = 1'b0;
        // a frame completing on the same edge as a select keeps the flag
        done_d = done_q;
        if (ser_done)        done_d = 1'b1;
        else if (sys_select) done_d = 1'b0;
    end

    // Buffer contents deliberately survive reset.
    always_ff @(posedge econet_clk) begin
        if (wr_en) mem_q[sys_addr[AW-1:0]] <= sys_wdata;
    end

    always_ff @(posedge econet_clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
            len_q   <= '0;
            rbyte_q <= 8'h00;
            rvld_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            go_q   <= accept;
            if (accept) len_q <= sys_tx_len;
            rvld_q <= byte_req;
            if (byte_req) rbyte_q <= rword[8*byte_idx[1:0] +: 8];
        end
    end

    econet_tx_serialiser #(
        .CNTW      (ECO_CNTWIDTH),
        .PRE_FLAGS (PRE_FLAGS)
    ) u_ser (
        .clk_i      (econet_clk),
        .rst_ni     (reset),
        .go_i       (go_q),
        .len_i      (len_q),
        .byte_req_o (byte_req),
        .byte_idx_o (byte_idx),
        .byte_vld_i (rvld_q),
        .byte_i     (rbyte_q),
        .tx_o       (econet_tx),
        .tx_en_o    (econet_tx_en),
        .done_o     (ser_done)
    );

    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_econet_tx_buffered.sv
// Bench for econet_tx_buffered: vector table of frames plus hand-written
// corner sequences; line bits are destuffed and checked against a scoreboard.
module tb_econet_tx_buffered;

    localparam int BUFSZ = 512;
    localparam int CNTW  = 9;
    localparam int PF    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sys_wr = 1'b0;
    logic            sys_select = 1'b0;
    logic [7:0]      sys_addr = 8'h00;
    logic [31:0]     sys_wdata = 32'h0;
    logic [CNTW:0]   sys_tx_len = '0;
    logic            sys_tx_start = 1'b0;
    logic            econet_tx, econet_tx_en, tx_busy, tx_done;

    econet_tx_buffered #(.ECO_BUFSZ(BUFSZ), .ECO_CNTWIDTH(CNTW), .PRE_FLAGS(PF)) dut (
        .econet_clk   (clk),
        .reset        (rst_n),
        .sys_wr       (sys_wr),
        .sys_select   (sys_select),
        .sys_addr     (sys_addr),
        .sys_wdata    (sys_wdata),
        .sys_tx_len   (sys_tx_len),
        .sys_tx_start (sys_tx_start),
        .econet_tx    (econet_tx),
        .econet_tx_en (econet_tx_en),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] membytes [BUFSZ];
    bit         rx_bits [$];
    logic [7:0] exp_q [$];
    int         exp_bits_q [$];

    always @(negedge clk) if (econet_tx_en) rx_bits.push_back(econet_tx);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) begin
                logic fb = c[0] ^ membytes[i][j];
                c = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        return c;
    endfunction

    function automatic int stuff_count(input int len, input logic [15:0] fcs);
        int run = 0;
        int n = 0;
        logic [7:0] b;
        for (int k = 0; k < len + 2; k++) begin
            b = (k < len) ? membytes[k] : ((k == len) ? fcs[7:0] : fcs[15:8]);
            for (int j = 0; j < 8; j++) begin
                if (b[j]) begin
                    run++;
                    if (run == 5) begin n++; run = 0; end
                end else run = 0;
            end
        end
        return n;
    endfunction

    task automatic fill(input int pat, input int len);
        for (int i = 0; i < len; i++)
            case (pat)
                0:       membytes[i] = 8'(8'h31 + i);
                1:       membytes[i] = 8'hFF;
                2:       membytes[i] = 8'($urandom_range(0, 255));
                default: membytes[i] = 8'(i * 7 + 3);
            endcase
    endtask

    task automatic write_word(input int w, input logic [31:0] data);
        sys_wr = 1'b1; sys_select = 1'b1; sys_addr = 8'(w); sys_wdata = data;
        @(negedge clk);
        sys_wr = 1'b0; sys_select = 1'b0;
    endtask

    task automatic load(input int len);
        for (int w = 0; w < (len + 3) / 4; w++)
            write_word(w, {membytes[4*w+3], membytes[4*w+2], membytes[4*w+1], membytes[4*w]});
    endtask

    task automatic push_expect(input int len, input bit known);
        logic [15:0] fcs = ~crc_model(len);
        for (int f = 0; f < PF; f++) exp_q.push_back(8'h7E);
        for (int i = 0; i < len; i++) exp_q.push_back(membytes[i]);
        if (known) begin
            exp_q.push_back(8'h6E); exp_q.push_back(8'h90);
        end else begin
            exp_q.push_back(fcs[7:0]); exp_q.push_back(fcs[15:8]);
        end
        exp_q.push_back(8'h7E);
        exp_bits_q.push_back(8*PF + 8*len + 16 + stuff_count(len, fcs) + 8);
    endtask

    task automatic start_frame(input int len, input bit acc);
        int bad = 0;
        rx_bits.delete();
        sys_tx_len = (CNTW+1)'(len); sys_tx_start = 1'b1;
        @(negedge clk);
        sys_tx_start = 1'b0;
        if (acc) begin
            chk("start_busy", tx_busy, 1);
            chk("start_en_latency", econet_tx_en, 0);
            @(negedge clk);
            chk("first_bit_en", econet_tx_en, 1);
            chk("first_bit_val", econet_tx, 0);
        end else begin
            repeat (20) begin
                @(negedge clk);
                if (tx_busy || econet_tx_en || !econet_tx) bad++;
            end
            chk("reject_idle", bad, 0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (tx_busy && n < 20000) begin @(negedge clk); n++; end
        chk("frame_timeout", (n < 20000) ? 1 : 0, 1);
        chk("end_done", tx_done, 1);
        chk("end_en", econet_tx_en, 0);
        chk("end_mark", econet_tx, 1);
    endtask

    task automatic clear_done();
        sys_select = 1'b1;
        @(negedge clk);
        sys_select = 1'b0;
        chk("done_clear", tx_done, 0);
    endtask

    task automatic decode_frame(input int len);
        int pos = 0;
        int ones = 0;
        logic [7:0] b;
        logic [15:0] res = 16'hFFFF;
        for (int f = 0; f < PF; f++) begin
            for (int j = 0; j < 8; j++) begin b[j] = rx_bits[pos]; pos++; end
            chk("open_flag", b, exp_q.pop_front());
        end
        for (int k = 0; k < len + 2; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (ones == 5) begin
                    chk("stuff_zero", rx_bits[pos], 0);
                    pos++; ones = 0;
                end
                b[j] = rx_bits[pos]; pos++;
                ones = b[j] ? ones + 1 : 0;
                res = (res >> 1) ^ (((res[0] ^ b[j]) == 1'b1) ? 16'h8408 : 16'h0);
            end
            chk((k < len) ? "data_byte" : "fcs_byte", b, exp_q.pop_front());
        end
        if (ones == 5) begin chk("stuff_zero", rx_bits[pos], 0); pos++; end
        for (int j = 0; j < 8; j++) begin b[j] = rx_bits[pos]; pos++; end
        chk("close_flag", b, exp_q.pop_front());
        chk("fcs_residue", res, 16'hF0B8);
        chk("frame_bits", rx_bits.size(), exp_bits_q.pop_front());
    endtask

    typedef struct {
        int len;
        int pat;
        bit acc;
    } vec_t;

    vec_t vecs [7];
    vec_t t;

    initial begin
        vecs[0] = '{len: 9,   pat: 0, acc: 1'b1};
        vecs[1] = '{len: 2,   pat: 1, acc: 1'b1};
        vecs[2] = '{len: 1,   pat: 3, acc: 1'b1};
        vecs[3] = '{len: 0,   pat: 3, acc: 1'b0};
        vecs[4] = '{len: 513, pat: 3, acc: 1'b0};
        vecs[5] = '{len: 37,  pat: 2, acc: 1'b1};
        vecs[6] = '{len: 512, pat: 3, acc: 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_tx", econet_tx, 1);
        chk("rst_en", econet_tx_en, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            t = vecs[v];
            if (t.acc) begin
                fill(t.pat, t.len);
                load(t.len);
                push_expect(t.len, t.pat == 0);
            end
            start_frame(t.len, t.acc);
            if (t.acc) begin
                wait_done();
                if (t.pat == 1) begin
                    chk("ff_stuff_after_bit5", rx_bits[8*PF + 5], 0);
                    chk("ff_stuff_after_bit10", rx_bits[8*PF + 11], 0);
                end
                decode_frame(t.len);
                clear_done();
            end
        end

        // writes during a frame are dropped; back-to-back start right after busy falls
        membytes[0] = 8'h11; membytes[1] = 8'h22; membytes[2] = 8'h33; membytes[3] = 8'h44;
        load(4);
        push_expect(4, 1'b0);
        start_frame(4, 1'b1);
        write_word(0, 32'hDEADBEEF);
        wait_done();
        decode_frame(4);
        push_expect(4, 1'b0);
        start_frame(4, 1'b1);
        wait_done();
        decode_frame(4);
        clear_done();

        // reset mid-DATA aborts at once, buffer survives
        fill(0, 9);
        load(9);
        start_frame(9, 1'b1);
        repeat (22) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_en", econet_tx_en, 0);
        chk("abort_tx", econet_tx, 1);
        chk("abort_busy", tx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_expect(9, 1'b1);
        start_frame(9, 1'b1);
        wait_done();
        decode_frame(9);
        clear_done();

        // select held across the setting edge: set wins, next edge clears
        fill(3, 1);
        load(1);
        push_expect(1, 1'b0);
        start_frame(1, 1'b1);
        sys_select = 1'b1;
        wait_done();
        @(negedge clk);
        chk("sel_next_clear", tx_done, 0);
        sys_select = 1'b0;
        decode_frame(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/econet_tx_buffered.md
ECONET_TX_BUFFERED -- requirements
Module: econet_tx_buffered

Interface
REQ-001 SHALL have parameter ECO_BUFSZ, default 512, transmit buffer size in bytes.
REQ-002 SHALL have parameter ECO_CNTWIDTH, default 9, byte-index width (log2 ECO_BUFSZ).
REQ-003 SHALL have parameter PRE_FLAGS, default 2, number of opening 0x7E flags (legal range 1..15).
REQ-004 SHALL have port econet_clk, input, 1, the only clock; one line bit per rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port sys_wr, input, 1, buffer write strobe.
REQ-007 SHALL have port sys_select, input, 1, block select; qualifies sys_wr and clears tx_done.
REQ-008 SHALL have port sys_addr, input, 8, 32-bit word address into the buffer.
REQ-009 SHALL have port sys_wdata, input, 32, write data; byte n of the frame is held in word n>>2, lane n&3, with lane 0 at [7:0].
REQ-010 SHALL have port sys_tx_len, input, ECO_CNTWIDTH+1, frame length in bytes, excluding the FCS.
REQ-011 SHALL have port sys_tx_start, input, 1, single-cycle start pulse.
REQ-012 SHALL have port econet_tx, output, 1, serial line data.
REQ-013 SHALL have port econet_tx_en, output, 1, line driver enable.
REQ-014 SHALL have port tx_busy, output, 1, high while a frame is in progress.
REQ-015 SHALL have port tx_done, output, 1, sticky frame-sent flag used as the interrupt source.

Function
REQ-016 SHALL write sys_wdata to buffer word sys_addr on a clock edge where sys_wr & sys_select & !tx_busy; writes made while tx_busy=1 SHALL be ignored.
REQ-017 SHALL accept sys_tx_start only when tx_busy=0 and 1 <= sys_tx_len <= ECO_BUFSZ; any other start SHALL be ignored with no output change.
REQ-018 SHALL latch sys_tx_len on the accepting edge, set tx_busy=1 on that edge, and drive the first flag bit on econet_tx with econet_tx_en=1 on the next edge (latency 1).
REQ-019 SHALL use FSM states IDLE -> FLAG_OPEN (PRE_FLAGS x 0x7E) -> DATA (len bytes) -> FCS (2 bytes) -> FLAG_CLOSE (1 x 0x7E) -> IDLE.
REQ-020 SHALL send every byte LSB first, one bit per econet_clk.
REQ-021 SHALL, in DATA and FCS only, insert a 0 bit after any 5 consecutive 1 bits; the inserted bit SHALL reset the ones count, and the count SHALL carry across byte and DATA/FCS boundaries.
REQ-022 SHALL NOT bit-stuff flags, and SHALL clear the ones count on entry to DATA.
REQ-023 SHALL compute CRC-16/X.25 over the data bytes only: reflected polynomial 0x8408, initial value 0xFFFF, inserted (stuffed) bits excluded.
REQ-024 SHALL transmit the FCS as the ones-complement of the CRC, low byte first, so that a receiver residue of 0xF0B8 reports a good frame.
REQ-025 SHALL, on the edge after the last closing-flag bit: drive econet_tx_en=0, drive econet_tx=1, clear tx_busy, and set tx_done=1.
REQ-026 SHALL clear tx_done synchronously on any edge where sys_select=1; if the set and clear conditions coincide, the set SHALL win.
REQ-027 SHALL drive econet_tx=1 (mark) and econet_tx_en=0 whenever the FSM is in IDLE.
REQ-028 SHALL make the frame duration in bits exactly 8*PRE_FLAGS + 8*len + 16 + stuffed_bits + 8.
REQ-029 SHALL allow a new start in the cycle after tx_busy falls.

Reset
REQ-030 SHALL, while reset=0, force: FSM=IDLE, econet_tx=1, econet_tx_en=0, tx_busy=0, tx_done=0, CRC=0xFFFF, ones count=0, latched length=0.
REQ-031 SHALL abort a frame in progress immediately on reset assertion, with no closing flag sent; buffer contents SHALL NOT be cleared.

Structure
REQ-032 SHALL take the constants ECO_FLAG=8'h7E, FCS_POLY=16'h8408, FCS_INIT=16'hFFFF and FCS_GOOD=16'hF0B8 from shared package econet_pkg, which the receiver also uses.
REQ-033 SHALL split the design into econet_tx_buffered (buffer, write port, length/start control, tx_done) and one sub-module econet_tx_serialiser (FSM, bit stuffing, CRC) with a byte-request/byte-valid handshake between them.

Verification
REQ-034 SHALL pass this scenario: reset, then load "123456789" (0x31..0x39), len=9, start -> bitstream after destuffing = 0x7E,0x7E, the 9 bytes, 0x6E,0x90, 0x7E; then tx_done=1.
REQ-035 SHALL pass this scenario: load two bytes 0xFF,0xFF, len=2 -> a 0 is inserted after bits 5 and 10 of the data, and the frame duration matches REQ-028 exactly.
REQ-036 SHALL pass this scenario: start with len=0, and separately with len=ECO_BUFSZ+1 -> tx_busy stays 0 and econet_tx_en stays 0.
REQ-037 SHALL pass this scenario: sys_wr to word 0 during a frame in progress -> the transmitted byte 0 is unchanged and the next frame sends the old word 0.
REQ-038 SHALL pass this scenario: reset asserted mid-DATA -> the same cycle gives econet_tx_en=0, econet_tx=1, tx_busy=0; a following start sends a full, correct frame.
REQ-039 SHALL pass this scenario: sys_select=1 held on the same edge that tx_done sets -> tx_done=1; sys_select=1 on the next edge -> tx_done=0.
